// File: rtl/adc_averager.sv
// adc_averager: windowed mean of the last 2^LOG_DEPTH ADC samples.
// Circular buffer plus running sum; mean is emitted one cycle after each update.
//
// Ports:
//   clk          rising-edge system clock
//   nreset       synchronous active-low reset
//   sample_in    unsigned ADC word, taken when sample_valid=1
//   sample_valid one sample per high cycle, back-to-back allowed
//   clear        synchronous flush of the window, active high
//   avg          windowed mean, truncated
//   avg_valid    one-cycle pulse when avg has just been updated
//   primed       high once the window is full
//   fill_count   samples held in the window, saturates at 2^LOG_DEPTH
module adc_averager #(
  parameter int WIDTH     = 10,
  parameter int LOG_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [WIDTH-1:0]     sample_in,
  input  logic                 sample_valid,
  input  logic                 clear,
  output logic [WIDTH-1:0]     avg,
  output logic                 avg_valid,
  output logic                 primed,
  output logic [LOG_DEPTH:0]   fill_count
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int SW    = WIDTH + LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] FULL = (LOG_DEPTH+1)'(DEPTH);

  typedef enum logic {
    FILL,
    RUN
  } state_t;

  state_t               state;
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [SW-1:0]        sum;
  logic                 pend;

  logic [WIDTH-1:0]     mem [DEPTH];

  logic [WIDTH-1:0]     old;
  logic [SW-1:0]        sum_next;
  logic [LOG_DEPTH:0]   fill_next;
  logic                 take;

  // Combinational read: the previous cycle's write is already in mem,
  // so back-to-back strobes see the correct evicted value.
  always_comb begin
    take      = sample_valid & ~clear;
    old       = mem[wr_ptr];
    fill_next = fill_count + (LOG_DEPTH+1)'(1);
    sum_next  = sum + SW'(sample_in);
    if (state == RUN)
      sum_next = sum + SW'(sample_in) - SW'(old);
  end

  // Buffer contents are never reset; fill_count gates their use.
  always_ff @(posedge clk) begin
    if (nreset && take)
      mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk) begin
    if (!nreset || clear) begin
      state      <= FILL;
      wr_ptr     <= '0;
      sum        <= '0;
      pend       <= 1'b0;
      avg        <= '0;
      avg_valid  <= 1'b0;
      primed     <= 1'b0;
      fill_count <= '0;
    end else begin
      // pend marks a sum updated on the previous edge while in RUN
      avg_valid <= pend;
      if (pend)
        avg <= sum[SW-1:LOG_DEPTH];
      pend <= 1'b0;
      if (sample_valid) begin
        sum    <= sum_next;
        wr_ptr <= wr_ptr + LOG_DEPTH'(1);
        unique case (state)
          FILL: begin
            fill_count <= fill_next;
            if (fill_next == FULL) begin
              state  <= RUN;
              primed <= 1'b1;
              pend   <= 1'b1;
            end
          end
          RUN: begin
            pend <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_averager.sv
// tb_adc_averager: directed stimulus with a scoreboard of expected means.
// Expected values come from a naive window model, compared on valid pulses.
module tb_adc_averager;

  localparam int W  = 10;
  localparam int LD = 3;
  localparam int N  = 1 << LD;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic [W-1:0]  sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          clear = 1'b0;
  logic [W-1:0]  avg;
  logic          avg_valid;
  logic          primed;
  logic [LD:0]   fill_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int           due;
    logic [W-1:0] v;
  } exp_t;

  exp_t       exp_q[$];
  logic [W-1:0] win[$];

  adc_averager #(.WIDTH(W), .LOG_DEPTH(LD)) dut (
    .clk(clk),
    .nreset(nreset),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .clear(clear),
    .avg(avg),
    .avg_valid(avg_valid),
    .primed(primed),
    .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: avg_valid must pulse exactly when the front entry is due.
  always @(negedge clk) begin
    logic ev;
    exp_t e;
    ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    checks++;
    assert (avg_valid === ev) else begin
      errors++;
      $error("FAIL avg_valid cyc %0d got %b exp %b", cyc, avg_valid, ev);
    end
    if (ev) begin
      e = exp_q.pop_front();
      checks++;
      assert (avg === e.v) else begin
        errors++;
        $error("FAIL avg cyc %0d got %0d exp %0d", cyc, avg, e.v);
      end
    end
  end

  // One cycle of stimulus; the model updates as the DUT will at the next edge.
  task automatic drive(input logic v, input int d,
                       input logic clr, input logic rn);
    int s;
    exp_t e;
    @(negedge clk);
    #1;
    sample_valid = v;
    sample_in    = W'(d);
    clear        = clr;
    nreset       = rn;
    if (!rn || clr) begin
      win.delete();
      exp_q.delete();
    end else if (v) begin
      win.push_back(W'(d));
      if (win.size() > N) void'(win.pop_front());
      if (win.size() == N) begin
        s = 0;
        foreach (win[i]) s += int'(win[i]);
        e.due = cyc + 2;
        e.v   = W'(s / N);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic chk(input string tag, input int f, input logic p);
    @(posedge clk);
    #2;
    checks++;
    assert (fill_count === (LD+1)'(f)) else begin
      errors++;
      $error("FAIL %s fill_count got %0d exp %0d", tag, fill_count, f);
    end
    checks++;
    assert (primed === p) else begin
      errors++;
      $error("FAIL %s primed got %b exp %b", tag, primed, p);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 0, 1'b0);
    checks++;
    assert (avg === '0) else begin
      errors++;
      $error("FAIL %s avg got %0d exp 0", tag, avg);
    end
    checks++;
    assert (avg_valid === 1'b0) else begin
      errors++;
      $error("FAIL %s avg_valid got %b exp 0", tag, avg_valid);
    end
  endtask

  initial begin
    drive(1'b0, 0, 1'b0, 1'b0);
    chk_zero("reset");
    idle(1);

    // prime with 100; fill_count tracked each edge
    for (int i = 1; i <= N; i++) begin
      drive(1'b1, 100, 1'b0, 1'b1);
      chk("fill100", i, (i == N));
    end
    idle(2);

    // four strobes of 200 -> 112,125,137,150
    for (int i = 0; i < 4; i++) drive(1'b1, 200, 1'b0, 1'b1);
    idle(2);

    // full scale then zero, continuous
    drive(1'b0, 0, 1'b1, 1'b1);
    chk_zero("clear1");
    for (int i = 0; i < N; i++) drive(1'b1, 1023, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) drive(1'b1, 0, 1'b0, 1'b1);
    idle(2);
    checks++;
    assert (avg === '0) else begin
      errors++;
      $error("FAIL ramp_end avg got %0d exp 0", avg);
    end

    // truncation: 0..7 -> 3, then 8 -> 4
    drive(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i <= N; i++) drive(1'b1, i, 1'b0, 1'b1);
    idle(2);
    checks++;
    assert (avg === W'(4)) else begin
      errors++;
      $error("FAIL trunc avg got %0d exp 4", avg);
    end

    // clear with a simultaneous strobe after 5 samples
    drive(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 1000, 1'b0, 1'b1);
    chk("part5", 5, 1'b0);
    drive(1'b1, 999, 1'b1, 1'b1);
    chk_zero("clear_drop");
    for (int i = 0; i < N; i++) drive(1'b1, 512, 1'b0, 1'b1);
    idle(2);
    checks++;
    assert (avg === W'(512)) else begin
      errors++;
      $error("FAIL clean512 avg got %0d exp 512", avg);
    end

    // reset while streaming: pending pulse dropped, refill needed
    for (int i = 0; i < 3; i++) drive(1'b1, 300 + i, 1'b0, 1'b1);
    drive(1'b1, 77, 1'b0, 1'b0);
    chk_zero("rst_stream");
    for (int i = 1; i < N; i++) begin
      drive(1'b1, 40 * i, 1'b0, 1'b1);
      chk("refill", i, 1'b0);
    end
    drive(1'b1, 50, 1'b0, 1'b1);
    chk("refill_full", N, 1'b1);
    idle(3);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain pending got %0d exp 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
